// File: rtl/dhsaf_pkg.sv
// Shared helpers for the DHSAF-II-CG datapath: pointer sizing and modular slot arithmetic.
package dhsaf_pkg;

  function automatic int ptr_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // (a - b) mod len for a in [0, len-1] and b in [0, len-1].
  function automatic int mod_sub(input int a, input int b, input int len);
    int d;
    d = a - b;
    if (d < 0) d = d + len;
    return d;
  endfunction

endpackage

// File: rtl/cg_tap_ctrl_reorder.sv
// Maps circular-buffer slots to age-ordered taps (lane 0 = newest); lanes at or beyond the fill count read as zero.
module cg_tap_reorder
  import dhsaf_pkg::*;
#(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 8,
  parameter int PTR_W  = ptr_w(LENGTH),
  parameter int FILL_W = $clog2(LENGTH + 1)
) (
  input  logic [LENGTH*WIDTH-1:0] reg_out,
  input  logic [PTR_W-1:0]        newest,
  input  logic [FILL_W-1:0]       fill,
  output logic [LENGTH*WIDTH-1:0] taps
);

  always_comb begin
    taps = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (i < int'(fill))
        taps[i*WIDTH +: WIDTH] = reg_out[mod_sub(int'(newest), i, LENGTH)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/cg_tap_ctrl.sv
// Write-side controller for the clock-gated tap delay line: one slot written per sample,
// negedge-registered one-hot clock enables, and an age-ordered, fill-masked tap readback.
module cg_tap_ctrl
  import dhsaf_pkg::*;
#(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_sample,
  input  logic                    clear,
  output logic [LENGTH-1:0]       cg_en,
  output logic [LENGTH*WIDTH-1:0] reg_in,
  input  logic [LENGTH*WIDTH-1:0] reg_out,
  output logic [LENGTH*WIDTH-1:0] tap_out,
  output logic                    tap_valid,
  output logic                    tap_full
);

  localparam int PTR_W  = ptr_w(LENGTH);
  localparam int FILL_W = $clog2(LENGTH + 1);

  // Handshake: in_valid alone qualifies in_sample at posedge; there is no ready,
  // every valid sample is taken unless clear is high in the same cycle.
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        slot_q;
  logic [PTR_W-1:0]        newest_q;
  logic [WIDTH-1:0]        sample_q;
  logic                    pend_q;
  logic [FILL_W-1:0]       fill_q;
  logic                    rd_pend_q;
  logic [FILL_W-1:0]       rd_fill_q;
  logic                    clr_q;
  logic [LENGTH*WIDTH-1:0] taps_next;

  wire accept = in_valid && !clear;

  // Stage 0: accept, pointer and fill bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      slot_q   <= '0;
      sample_q <= '0;
      pend_q   <= 1'b0;
      fill_q   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
    end else if (accept) begin
      sample_q <= in_sample;
      slot_q   <= wr_ptr;
      wr_ptr   <= (wr_ptr == PTR_W'(LENGTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      pend_q   <= 1'b1;
      if (fill_q != FILL_W'(LENGTH)) fill_q <= fill_q + FILL_W'(1);
    end else begin
      pend_q <= 1'b0;
    end
  end

  // Enables change only while clk is low so the AND-gated slot clocks cannot glitch.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) cg_en <= '0;
    else       cg_en <= pend_q ? (LENGTH'(1) << slot_q) : '0;
  end

  assign reg_in = {LENGTH{sample_q}};

  // Stage 1: the slot captures on this edge; remember which write to report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_fill_q <= '0;
      newest_q  <= '0;
      clr_q     <= 1'b0;
    end else begin
      clr_q     <= clear;
      rd_pend_q <= pend_q && !clear;
      rd_fill_q <= clear ? '0 : fill_q;
      if (pend_q) newest_q <= slot_q;
    end
  end

  cg_tap_reorder #(
    .LENGTH (LENGTH),
    .WIDTH  (WIDTH),
    .PTR_W  (PTR_W),
    .FILL_W (FILL_W)
  ) u_reorder (
    .reg_out (reg_out),
    .newest  (newest_q),
    .fill    (rd_fill_q),
    .taps    (taps_next)
  );

  // Stage 2: registered ordered taps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_out   <= '0;
      tap_valid <= 1'b0;
      tap_full  <= 1'b0;
    end else begin
      tap_full <= (rd_fill_q == FILL_W'(LENGTH));
      if (clr_q) begin
        tap_out   <= '0;
        tap_valid <= 1'b0;
      end else if (rd_pend_q) begin
        tap_out   <= taps_next;
        tap_valid <= 1'b1;
      end else begin
        tap_valid <= 1'b0;
      end
    end
  end

  a_cg_en_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(cg_en));

endmodule

// File: doc/cg_tap_ctrl.md
# cg_tap_ctrl

- Write-side controller for the clock-gated tap delay line of the DHSAF-II-CG datapath.
- Turns the delay line into a circular buffer: each accepted input sample is written into exactly one register slot, so only one slot's clock toggles per sample.
- Drives the delay unit's per-slot clock enables and its packed data input, and reads back its packed output.
- Presents an age-ordered, zero-masked tap vector to the spline/FIR stages downstream.

## Interface
Parameters:
- LENGTH, 16: number of taps/slots, ≥2, need not be a power of two.
- WIDTH, 8: sample width in bits.

Ports:
- clk  in  1  system clock. One clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample is presented this cycle. There is no backpressure, so every valid sample is accepted.
- in_sample  in  WIDTH  input sample x[n].
- clear  in  1  synchronous flush of buffer history.
- cg_en  out  LENGTH  one-hot per-slot clock enable to the delay unit.
- reg_in  out  LENGTH*WIDTH  data to the delay unit: the pending sample broadcast to every slot.
- reg_out  in  LENGTH*WIDTH  slot contents read back from the delay unit.
- tap_out  out  LENGTH*WIDTH  ordered taps: lane i = x[n-i], lane 0 = newest.
- tap_valid  out  1  one-cycle pulse when tap_out reflects a new sample.
- tap_full  out  1  LENGTH samples have been written since reset or clear.

## Operation
State:
- wr_ptr: 0..LENGTH-1.
- newest_q: slot of the last write.
- sample_q: WIDTH bits.
- pend_q: 1 bit.
- fill_q: 0..LENGTH, saturating.
- cg_en register.
- Output registers: tap_out, tap_valid.

Accept (posedge k, in_valid=1):
- sample_q ← in_sample.
- slot_q ← wr_ptr.
- wr_ptr ← wr_ptr+1, or 0 when wr_ptr = LENGTH-1. The wrap is explicit compare-to-LENGTH-1, never a natural overflow.
- pend_q ← 1.
- fill_q ← min(fill_q+1, LENGTH).

No accept: pend_q ← 0 and all other state holds.

Gated-enable generation:
- cg_en updates on the falling edge of clk only, so it is stable while clk is high and the AND-gated clock cannot glitch.
- cg_en ← pend_q ? onehot(slot_q) : 0.
- Invariant: cg_en is at most one-hot, checked by an assertion.
- reg_in = {LENGTH{sample_q}}.

Readback and ordering (posedge after the slot write):
- Lane i of tap_out ← reg_out[slot (newest_q − i) mod LENGTH] when i < fill_q, else 0.
- tap_valid ← 1 for one cycle.

clear (synchronous):
- wr_ptr ← 0, fill_q ← 0, pend_q ← 0.
- cg_en is cleared at the next falling edge.
- tap_out ← 0 at the next posedge.
- Slot contents are not erased; stale data is hidden by the fill mask.
- clear together with in_valid: clear wins and the sample is dropped.

Reset (asynchronous) forces these outputs and state:
- cg_en = 0, reg_in = 0, tap_out = 0, tap_valid = 0, tap_full = 0.
- wr_ptr = 0, fill_q = 0, pend_q = 0, sample_q = 0.
- Reset mid-operation abandons any pending write. The delay unit shares reset, so the slots are zeroed too.

tap_full = (fill_q == LENGTH), registered, and stays high until reset or clear.

## Timing
- in_valid sampled at posedge k.
- cg_en one-hot from negedge k to negedge k+1.
- Delay-unit slot captures at posedge k+1.
- tap_out/tap_valid registered at posedge k+2. Latency from accept to tap_valid is 2 cycles.
- Throughput is one sample per cycle. Back-to-back valid samples give consecutive one-hot cg_en values and consecutive tap_valid pulses.
- The reordered tap_out is computed from the newest_q value of the write being reported, not the live wr_ptr.
- fill_q increments at accept. The mask applied at k+2 uses the fill count that includes sample k.
- tap_full rises in the same cycle as the tap_valid of the LENGTH-th sample.

## Structure
- Shared package (dhsaf_pkg):
  - the pointer width function/constant PTR_W = $clog2(LENGTH);
  - a modular-subtract helper for (a − b) mod LENGTH.
- Natural sub-module: cg_tap_reorder. It is combinational and maps (reg_out, newest_q, fill_q) to the masked, age-ordered vector.
- The top keeps the pointer, fill, negedge cg_en logic and output registers.
- Bench instantiates cg_tap_ctrl with the existing DelayUnit_CG.

## Test plan
- Reset, then LENGTH=4, WIDTH=8, samples 1,2,3 on consecutive cycles:
  - cg_en shows 0001, 0010, 0100 at successive negedges;
  - the final tap_out is {0,1,2,3} (lane3..lane0);
  - tap_full=0.
- Continue with 4,5,6 (wrap):
  - wr_ptr returns to 0, then 1;
  - tap_out = {3,4,5,6};
  - tap_full goes high with sample 4;
  - cg_en is never multi-hot.
- Gappy input (valid on cycles 0,3,4):
  - tap_valid pulses at cycles 2,5,6 only;
  - cg_en = 0 during idle cycles;
  - the gated clock toggles only for the written slot.
- clear asserted after 6 samples, then sample 9:
  - tap_out = {0,0,0,9};
  - tap_full = 0;
  - a clear coincident with in_valid drops that sample.
- Asynchronous reset asserted mid-burst, between negedge and posedge:
  - cg_en/tap_out/tap_valid go to 0 immediately;
  - after release, the first sample lands in slot 0.
- LENGTH=5 (non-power-of-two), 12 samples:
  - the pointer wraps 4→0;
  - tap_out matches a reference shift-register model every tap_valid.
